// File: rtl/mem_bus_ctrl_pkg.sv
// Shared load/store bus constants: widths, exception codes, width encodings,
// the target request payload and the address-window helper.
package mem_bus_ctrl_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned WIDTH_W       = 2;
    localparam int unsigned EXCEPTION_LEN = 4;

    localparam logic [WIDTH_W-1:0] MEM_WIDTH_NONE = 2'd0;
    localparam logic [WIDTH_W-1:0] MEM_WIDTH_BYTE = 2'd1;
    localparam logic [WIDTH_W-1:0] MEM_WIDTH_HALF = 2'd2;
    localparam logic [WIDTH_W-1:0] MEM_WIDTH_WORD = 2'd3;

    localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                   = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ     = 4'd1;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE    = 4'd2;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_MEM_READ  = 4'd3;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_MEM_WRITE = 4'd4;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_MEM_TIMEOUT          = 4'd5;

    localparam logic [ADDR_W-1:0] RAM_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [ADDR_W-1:0] RAM_SIZE_DEFAULT = 32'h0001_0000;
    localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT  = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] IO_SIZE_DEFAULT  = 32'h0000_0004;
    localparam int unsigned       TIMEOUT_DEFAULT  = 16;

    typedef enum logic {
        TGT_RAM = 1'b0,
        TGT_IO  = 1'b1
    } mem_tgt_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        logic [WIDTH_W-1:0] width;
        logic               is_read;
    } tgt_req_t;

    // Unsigned window test; written as a difference so a window ending at 2^32 works.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_load_ext.sv
// Combinational width selection and sign/zero extension of right-aligned load data.
module mem_load_ext
    import mem_bus_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [WIDTH_W-1:0] width,
    input  logic               is_signed,
    output logic [DATA_W-1:0]  data_c
);

    always_comb begin
        data_c = '0;
        case (width)
            MEM_WIDTH_BYTE: data_c = {{24{is_signed & data[7]}}, data[7:0]};
            MEM_WIDTH_HALF: data_c = {{16{is_signed & data[15]}}, data[15:0]};
            MEM_WIDTH_WORD: data_c = data;
            default:        data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Load/store front-end: decodes a MEM-stage request to RAM or IO, strobes the
// target once, waits for completion or timeout, and returns one response pulse.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RAM_BASE       = RAM_BASE_DEFAULT,
    parameter logic [ADDR_W-1:0] RAM_SIZE       = RAM_SIZE_DEFAULT,
    parameter logic [ADDR_W-1:0] IO_BASE        = IO_BASE_DEFAULT,
    parameter logic [ADDR_W-1:0] IO_SIZE        = IO_SIZE_DEFAULT,
    parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr_In,
    input  logic [DATA_W-1:0]        data_In,
    input  logic [WIDTH_W-1:0]       dataWidth_In,
    input  logic                     isRead_In,
    input  logic                     isSigned_In,
    input  logic                     inputValid_In,
    output logic                     ready_Out,
    output logic [DATA_W-1:0]        data_Out,
    output logic                     operationOK_Out,
    output logic [EXCEPTION_LEN-1:0] exception_Out,
    output logic [ADDR_W-1:0]        ramAddr_Out,
    output logic [DATA_W-1:0]        ramData_Out,
    output logic [WIDTH_W-1:0]       ramDataWidth_Out,
    output logic                     ramIsRead_Out,
    output logic                     ramInputValid_Out,
    input  logic [DATA_W-1:0]        ramData_In,
    input  logic                     ramOperationOK_In,
    input  logic [EXCEPTION_LEN-1:0] ramException_In,
    output logic [ADDR_W-1:0]        ioAddr_Out,
    output logic [DATA_W-1:0]        ioData_Out,
    output logic [WIDTH_W-1:0]       ioDataWidth_Out,
    output logic                     ioIsRead_Out,
    output logic                     ioInputValid_Out,
    input  logic [DATA_W-1:0]        ioData_In,
    input  logic                     ioOperationOK_In,
    input  logic [EXCEPTION_LEN-1:0] ioException_In
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                   state, state_nxt;
    mem_tgt_e                 req_tgt, req_tgt_nxt;
    logic [WIDTH_W-1:0]       req_width, req_width_nxt;
    logic                     req_is_read, req_is_read_nxt;
    logic                     req_is_signed, req_is_signed_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    tgt_req_t                 ram_req, ram_req_nxt;
    tgt_req_t                 io_req, io_req_nxt;
    logic                     ram_valid_nxt, io_valid_nxt;
    logic                     ready_nxt, op_ok_nxt;
    logic [DATA_W-1:0]        data_nxt;
    logic [EXCEPTION_LEN-1:0] exc_nxt;

    logic                     hit_ram_c, hit_io_c, misaligned_c;
    logic [EXCEPTION_LEN-1:0] sel_exc_c;
    logic                     sel_ok_c;
    logic [DATA_W-1:0]        sel_rdata_c, ext_data_c;

    // Request decode, evaluated against the live inputs in the accept cycle
    assign hit_ram_c    = in_window(addr_In, RAM_BASE, RAM_SIZE);
    assign hit_io_c     = !hit_ram_c && in_window(addr_In, IO_BASE, IO_SIZE);
    assign misaligned_c = ((dataWidth_In == MEM_WIDTH_HALF) && addr_In[0]) ||
                          ((dataWidth_In == MEM_WIDTH_WORD) && (addr_In[1:0] != 2'b00));

    assign sel_exc_c   = (req_tgt == TGT_RAM) ? ramException_In   : ioException_In;
    assign sel_ok_c    = (req_tgt == TGT_RAM) ? ramOperationOK_In : ioOperationOK_In;
    assign sel_rdata_c = (req_tgt == TGT_RAM) ? ramData_In        : ioData_In;

    mem_load_ext u_load_ext (
        .data      (sel_rdata_c),
        .width     (req_width),
        .is_signed (req_is_signed),
        .data_c    (ext_data_c)
    );

    assign ramAddr_Out      = ram_req.addr;
    assign ramData_Out      = ram_req.data;
    assign ramDataWidth_Out = ram_req.width;
    assign ramIsRead_Out    = ram_req.is_read;
    assign ioAddr_Out       = io_req.addr;
    assign ioData_Out       = io_req.data;
    assign ioDataWidth_Out  = io_req.width;
    assign ioIsRead_Out     = io_req.is_read;

    // Next-state and next-output computation
    always_comb begin
        state_nxt         = state;
        req_tgt_nxt       = req_tgt;
        req_width_nxt     = req_width;
        req_is_read_nxt   = req_is_read;
        req_is_signed_nxt = req_is_signed;
        cnt_nxt           = cnt;
        ram_req_nxt       = ram_req;
        io_req_nxt        = io_req;
        ram_valid_nxt     = 1'b0;
        io_valid_nxt      = 1'b0;
        op_ok_nxt         = 1'b0;
        data_nxt          = '0;
        exc_nxt           = EXCEP_OK;
        ready_nxt         = 1'b0;

        case (state)
            S_IDLE: begin
                if (inputValid_In && ready_Out) begin
                    req_width_nxt     = dataWidth_In;
                    req_is_read_nxt   = isRead_In;
                    req_is_signed_nxt = isSigned_In;
                    if ((dataWidth_In == MEM_WIDTH_NONE) || !(hit_ram_c || hit_io_c)) begin
                        state_nxt = S_RESP;
                        op_ok_nxt = 1'b1;
                        exc_nxt   = isRead_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
                    end else if (misaligned_c) begin
                        state_nxt = S_RESP;
                        op_ok_nxt = 1'b1;
                        exc_nxt   = isRead_In ? EXCEP_MISALIGNED_MEM_READ
                                              : EXCEP_MISALIGNED_MEM_WRITE;
                    end else if (hit_ram_c) begin
                        state_nxt     = S_ISSUE;
                        req_tgt_nxt   = TGT_RAM;
                        ram_valid_nxt = 1'b1;
                        ram_req_nxt   = '{addr: addr_In - RAM_BASE, data: data_In,
                                          width: dataWidth_In, is_read: isRead_In};
                    end else begin
                        state_nxt    = S_ISSUE;
                        req_tgt_nxt  = TGT_IO;
                        io_valid_nxt = 1'b1;
                        io_req_nxt   = '{addr: addr_In - IO_BASE, data: data_In,
                                         width: dataWidth_In, is_read: isRead_In};
                    end
                end
            end
            S_ISSUE: begin
                if (sel_exc_c != EXCEP_OK) begin
                    state_nxt = S_RESP;
                    op_ok_nxt = 1'b1;
                    exc_nxt   = sel_exc_c;
                end else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Completion takes priority over a coincident timeout
                if (sel_ok_c) begin
                    state_nxt = S_RESP;
                    op_ok_nxt = 1'b1;
                    data_nxt  = req_is_read ? ext_data_c : '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = S_RESP;
                    op_ok_nxt = 1'b1;
                    exc_nxt   = EXCEP_MEM_TIMEOUT;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Target-side request fields are only presented while a transaction is open
        if (state_nxt == S_IDLE) begin
            ram_req_nxt = '0;
            io_req_nxt  = '0;
            ready_nxt   = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            req_tgt           <= TGT_RAM;
            req_width         <= MEM_WIDTH_NONE;
            req_is_read       <= 1'b0;
            req_is_signed     <= 1'b0;
            cnt               <= '0;
            ram_req           <= '0;
            io_req            <= '0;
            ramInputValid_Out <= 1'b0;
            ioInputValid_Out  <= 1'b0;
            ready_Out         <= 1'b1;
            operationOK_Out   <= 1'b0;
            data_Out          <= '0;
            exception_Out     <= EXCEP_OK;
        end else begin
            state             <= state_nxt;
            req_tgt           <= req_tgt_nxt;
            req_width         <= req_width_nxt;
            req_is_read       <= req_is_read_nxt;
            req_is_signed     <= req_is_signed_nxt;
            cnt               <= cnt_nxt;
            ram_req           <= ram_req_nxt;
            io_req            <= io_req_nxt;
            ramInputValid_Out <= ram_valid_nxt;
            ioInputValid_Out  <= io_valid_nxt;
            ready_Out         <= ready_nxt;
            operationOK_Out   <= op_ok_nxt;
            data_Out          <= data_nxt;
            exception_Out     <= exc_nxt;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus randomized requests
// against a transaction-level reference model and a reactive target model.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam logic [31:0] RB = 32'h8000_0000;
    localparam logic [31:0] RS = 32'h0001_0000;
    localparam logic [31:0] IB = 32'h1000_0000;
    localparam logic [31:0] IS = 32'h0000_0004;
    localparam int          TO = 16;

    logic        clk, rst;
    logic [31:0] addr_In, data_In;
    logic [1:0]  dataWidth_In;
    logic        isRead_In, isSigned_In, inputValid_In;
    logic        ready_Out, operationOK_Out;
    logic [31:0] data_Out;
    logic [EXCEPTION_LEN-1:0] exception_Out;
    logic [31:0] ramAddr_Out, ramData_Out, ioAddr_Out, ioData_Out;
    logic [1:0]  ramDataWidth_Out, ioDataWidth_Out;
    logic        ramIsRead_Out, ioIsRead_Out, ramInputValid_Out, ioInputValid_Out;
    logic [31:0] ramData_In, ioData_In;
    logic        ramOperationOK_In, ioOperationOK_In;
    logic [EXCEPTION_LEN-1:0] ramException_In, ioException_In;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_ctrl #(
        .RAM_BASE(RB), .RAM_SIZE(RS), .IO_BASE(IB), .IO_SIZE(IS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_In(addr_In), .data_In(data_In), .dataWidth_In(dataWidth_In),
        .isRead_In(isRead_In), .isSigned_In(isSigned_In), .inputValid_In(inputValid_In),
        .ready_Out(ready_Out), .data_Out(data_Out), .operationOK_Out(operationOK_Out),
        .exception_Out(exception_Out),
        .ramAddr_Out(ramAddr_Out), .ramData_Out(ramData_Out),
        .ramDataWidth_Out(ramDataWidth_Out), .ramIsRead_Out(ramIsRead_Out),
        .ramInputValid_Out(ramInputValid_Out), .ramData_In(ramData_In),
        .ramOperationOK_In(ramOperationOK_In), .ramException_In(ramException_In),
        .ioAddr_Out(ioAddr_Out), .ioData_Out(ioData_Out),
        .ioDataWidth_Out(ioDataWidth_Out), .ioIsRead_Out(ioIsRead_Out),
        .ioInputValid_Out(ioInputValid_Out), .ioData_In(ioData_In),
        .ioOperationOK_In(ioOperationOK_In), .ioException_In(ioException_In)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_targets();
        ramData_In = '0; ioData_In = '0;
        ramOperationOK_In = 1'b0; ioOperationOK_In = 1'b0;
        ramException_In = EXCEP_OK; ioException_In = EXCEP_OK;
    endtask

    // One request; ok_dly = cycles after the strobe at which the target answers (0 = never)
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                           input logic rd, input logic sg, input int ok_dly,
                           input logic [EXCEPTION_LEN-1:0] t_exc, input logic [31:0] t_rdata);
        longint unsigned ua;
        longint          sv;
        bit              in_ram, in_io, aligned, sel_io;
        int              exp_lat, exp_ram, exp_io, got_lat, ram_cnt, io_cnt, strobe_cyc;
        logic [31:0]     exp_data, exp_off, got_data;
        logic [EXCEPTION_LEN-1:0] exp_exc, got_exc;

        ua       = longint'(a);
        in_ram   = (ua >= RB) && (ua < longint'(RB) + longint'(RS));
        in_io    = !in_ram && (ua >= IB) && (ua < longint'(IB) + longint'(IS));
        aligned  = (w == 2'd2) ? (a % 2 == 0) : (w == 2'd3) ? (a % 4 == 0) : 1'b1;
        exp_data = '0; exp_exc = EXCEP_OK; exp_ram = 0; exp_io = 0; exp_off = '0;
        if (w == 2'd0 || !(in_ram || in_io)) begin
            exp_exc = rd ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
            exp_lat = 1;
        end else if (!aligned) begin
            exp_exc = rd ? EXCEP_MISALIGNED_MEM_READ : EXCEP_MISALIGNED_MEM_WRITE;
            exp_lat = 1;
        end else begin
            if (in_ram) begin exp_ram = 1; exp_off = a - RB; end
            else        begin exp_io  = 1; exp_off = a - IB; end
            if (t_exc != EXCEP_OK) begin
                exp_exc = t_exc;
                exp_lat = 2;
            end else if (ok_dly >= 1 && ok_dly <= TO) begin
                exp_lat = 2 + ok_dly;
                if (rd) begin
                    if (w == 2'd1) begin
                        sv = longint'(t_rdata % 32'd256);
                        if (sg && sv >= 128) sv = sv - 256;
                    end else if (w == 2'd2) begin
                        sv = longint'(t_rdata % 32'd65536);
                        if (sg && sv >= 32768) sv = sv - 65536;
                    end else begin
                        sv = longint'(t_rdata);
                    end
                    exp_data = 32'(sv);
                end
            end else begin
                exp_exc = EXCEP_MEM_TIMEOUT;
                exp_lat = 2 + TO;
            end
        end

        @(negedge clk);
        chk("ready_idle", 32'(ready_Out), 32'd1);
        addr_In = a; data_In = d; dataWidth_In = w; isRead_In = rd; isSigned_In = sg;
        inputValid_In = 1'b1;
        @(negedge clk);
        inputValid_In = 1'b0;
        addr_In = $urandom; data_In = $urandom;

        got_lat = 0; got_data = '0; got_exc = '0; ram_cnt = 0; io_cnt = 0;
        strobe_cyc = 0; sel_io = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (operationOK_Out) begin
                got_lat = n; got_data = data_Out; got_exc = exception_Out;
                break;
            end
            ramException_In = EXCEP_OK; ioException_In = EXCEP_OK;
            ramOperationOK_In = 1'b0; ioOperationOK_In = 1'b0;
            ramData_In = $urandom; ioData_In = $urandom;
            if (ramInputValid_Out) begin
                ram_cnt++; strobe_cyc = n; sel_io = 1'b0;
                chk("ram_offset", ramAddr_Out, exp_off);
                ramException_In = t_exc;
            end
            if (ioInputValid_Out) begin
                io_cnt++; strobe_cyc = n; sel_io = 1'b1;
                chk("io_offset", ioAddr_Out, exp_off);
                ioException_In = t_exc;
            end
            if (strobe_cyc > 0 && ok_dly > 0 && n == strobe_cyc + ok_dly) begin
                if (sel_io) begin ioOperationOK_In = 1'b1; ioData_In = t_rdata; end
                else        begin ramOperationOK_In = 1'b1; ramData_In = t_rdata; end
            end
            @(negedge clk);
        end
        clear_targets();
        chk("latency", 32'(got_lat), 32'(exp_lat));
        chk("data", got_data, exp_data);
        chk("exception", 32'(got_exc), 32'(exp_exc));
        chk("ram_strobes", 32'(ram_cnt), 32'(exp_ram));
        chk("io_strobes", 32'(io_cnt), 32'(exp_io));
        @(negedge clk);
        chk("resp_single", 32'(operationOK_Out), 32'd0);
        chk("idle_data", data_Out, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rw;
        int          cls, dly;
        logic [EXCEPTION_LEN-1:0] te;
        logic [31:0] edges [6];
        int          ok_seen;

        rst = 1'b1; inputValid_In = 1'b0; addr_In = '0; data_In = '0;
        dataWidth_In = '0; isRead_In = 1'b0; isSigned_In = 1'b0;
        clear_targets();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_Out), 32'd1);
        chk("rst_ok", 32'(operationOK_Out), 32'd0);
        chk("rst_data", data_Out, 32'd0);
        chk("rst_exc", 32'(exception_Out), 32'd0);
        chk("rst_ramvalid", 32'(ramInputValid_Out), 32'd0);
        rst = 1'b0;

        run_txn(IB, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, 1, EXCEP_OK, 32'hDEAD_BEEF);
        run_txn(RB + 32'd8, 32'd0, MEM_WIDTH_BYTE, 1'b1, 1'b1, 1, EXCEP_OK, 32'h0000_0080);
        run_txn(RB + 32'd8, 32'd0, MEM_WIDTH_BYTE, 1'b1, 1'b0, 1, EXCEP_OK, 32'h0000_0080);
        run_txn(RB + 32'd6, 32'd0, MEM_WIDTH_HALF, 1'b1, 1'b1, 2, EXCEP_OK, 32'h1234_8000);
        run_txn(RB + 32'd2, 32'h55AA_55AA, MEM_WIDTH_WORD, 1'b0, 1'b0, 1, EXCEP_OK, 32'd0);
        run_txn(32'h0, 32'h1, MEM_WIDTH_WORD, 1'b0, 1'b0, 1, EXCEP_OK, 32'd0);
        run_txn(IB, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, 1, EXCEP_INVALID_MEM_READ, 32'hFFFF_FFFF);
        run_txn(RB + 32'd4, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, 0, EXCEP_OK, 32'h1111_1111);
        run_txn(RB + 32'd4, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, TO, EXCEP_OK, 32'h2222_2222);
        run_txn(RB + 32'd4, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, TO + 1, EXCEP_OK, 32'h3333_3333);
        run_txn(RB + RS - 32'd4, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, 3, EXCEP_OK, 32'hCAFE_F00D);
        run_txn(RB + RS, 32'd0, MEM_WIDTH_BYTE, 1'b1, 1'b0, 1, EXCEP_OK, 32'd0);
        run_txn(IB + 32'd3, 32'h77, MEM_WIDTH_BYTE, 1'b0, 1'b0, 1, EXCEP_OK, 32'd0);
        run_txn(IB + IS, 32'd0, MEM_WIDTH_BYTE, 1'b1, 1'b0, 1, EXCEP_OK, 32'd0);
        run_txn(RB, 32'd0, MEM_WIDTH_NONE, 1'b1, 1'b0, 1, EXCEP_OK, 32'd0);

        // Reset between clock edges while waiting on a silent RAM
        @(negedge clk);
        addr_In = RB + 32'd16; dataWidth_In = MEM_WIDTH_WORD; isRead_In = 1'b1;
        inputValid_In = 1'b1;
        @(negedge clk);
        inputValid_In = 1'b0;
        repeat (4) @(negedge clk);
        chk("wait_ramaddr", ramAddr_Out, 32'd16);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready_Out), 32'd1);
        chk("midrst_ok", 32'(operationOK_Out), 32'd0);
        chk("midrst_ramaddr", ramAddr_Out, 32'd0);
        chk("midrst_ramread", 32'(ramIsRead_Out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ok_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (operationOK_Out) ok_seen++;
        end
        chk("postrst_no_resp", 32'(ok_seen), 32'd0);
        run_txn(RB + 32'd16, 32'd0, MEM_WIDTH_WORD, 1'b1, 1'b0, 1, EXCEP_OK, 32'h0BAD_CAFE);

        edges[0] = RB - 32'd1; edges[1] = RB + RS - 32'd1; edges[2] = RB + RS;
        edges[3] = IB - 32'd1; edges[4] = IB + IS - 32'd1; edges[5] = 32'hFFFF_FFFC;
        for (int t = 0; t < 200; t++) begin
            cls = $urandom_range(0, 3);
            rw  = 2'($urandom_range(0, 3));
            case (cls)
                0:       ra = RB + 32'($urandom_range(0, 32'h0000_FFFF));
                1:       ra = IB + 32'($urandom_range(0, 3));
                2:       ra = $urandom;
                default: ra = edges[$urandom_range(0, 5)];
            endcase
            if (cls < 2 && $urandom_range(0, 3) != 0) begin
                if (rw == MEM_WIDTH_HALF) ra[0] = 1'b0;
                if (rw == MEM_WIDTH_WORD) ra[1:0] = 2'b00;
            end
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 3);
            te  = ($urandom_range(0, 7) == 0) ? EXCEP_INVALID_MEM_WRITE : EXCEP_OK;
            run_txn(ra, $urandom, rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    dly, te, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
